// File: rtl/data_mem_dump_if.sv
// Bundles the data-memory read port and the UART TX byte stream of the dump engine.
// master = dump engine, slave = memory/UART side.
interface data_mem_dump_if #(
  parameter int len_addr = 11,
  parameter int len_data = 16
);
  logic                mem_rd;
  logic [len_addr-1:0] mem_addr;
  logic [len_data-1:0] mem_data;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    output mem_rd, mem_addr, tx_data, tx_valid,
    input  mem_data, tx_ready
  );

  modport slave (
    input  mem_rd, mem_addr, tx_data, tx_valid,
    output mem_data, tx_ready
  );
endinterface

// File: rtl/data_mem_dump.sv
// Streams a block of 16-bit data-memory words to UART TX as bytes, high byte first.
// DUMP_CHECKSUM_EN appends an XOR checksum byte of everything sent in the dump.
module data_mem_dump #(
  parameter int len_addr  = 11,
  parameter int len_data  = 16,
  parameter int ram_depth = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [len_addr-1:0] base_addr,
  input  logic [len_addr:0]   word_count,
  output logic                busy,
  output logic                done,
  data_mem_dump_if.master     bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, SEND_HI, SEND_LO, SEND_CK, FINISH
  } state_t;

`ifdef DUMP_CHECKSUM_EN
  localparam state_t after_last = SEND_CK;
`else
  localparam state_t after_last = FINISH;
`endif

  localparam logic [len_addr:0]   depth_w   = (len_addr+1)'(ram_depth);
  localparam logic [len_addr-1:0] last_addr = len_addr'(ram_depth - 1);

  state_t              state, state_n;
  logic [len_addr-1:0] cur_addr;
  logic [len_addr:0]   remaining;
  logic [len_data-1:0] word;
  logic [len_addr:0]   cnt_sat;
  logic                tx_vld;
  logic [7:0]          tx_dat;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign cnt_sat = (word_count > depth_w) ? depth_w : word_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    tx_vld  = 1'b0;
    tx_dat  = 8'h00;
    unique case (state)
      IDLE:    if (start) state_n = (cnt_sat == '0) ? after_last : ISSUE;
      ISSUE:   state_n = CAPTURE;
      CAPTURE: state_n = SEND_HI;
      SEND_HI: begin
        tx_vld = 1'b1;
        tx_dat = word[15:8];
        if (bus.tx_ready) state_n = SEND_LO;
      end
      SEND_LO: begin
        tx_vld = 1'b1;
        tx_dat = word[7:0];
        if (bus.tx_ready)
          state_n = (remaining == (len_addr+1)'(1)) ? after_last : ISSUE;
      end
      SEND_CK: begin
        tx_vld = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        tx_dat = csum;
`endif
        if (bus.tx_ready) state_n = FINISH;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory registers the address, so mem_addr simply follows cur_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      word      <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      if (state == IDLE && start) begin
        cur_addr  <= base_addr;
        remaining <= cnt_sat;
`ifdef DUMP_CHECKSUM_EN
        csum      <= 8'h00;
`endif
      end
      if (state == CAPTURE) word <= bus.mem_data;
`ifdef DUMP_CHECKSUM_EN
      if (state == SEND_HI && bus.tx_ready) csum <= csum ^ word[15:8];
`endif
      if (state == SEND_LO && bus.tx_ready) begin
        remaining <= remaining - (len_addr+1)'(1);
        cur_addr  <= (cur_addr == last_addr) ? '0 : cur_addr + len_addr'(1);
`ifdef DUMP_CHECKSUM_EN
        csum      <= csum ^ word[7:0];
`endif
      end
    end
  end

  // Memory writes need Rd=0, so the read enable covers the whole busy window.
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign bus.mem_rd   = busy;
  assign bus.mem_addr = cur_addr;
  assign bus.tx_valid = tx_vld;
  assign bus.tx_data  = tx_dat;

endmodule

// File: tb/tb_data_mem_dump.sv
// Directed bench for data_mem_dump: behavioural data memory, byte capture, hand-checked vectors.
module tb_data_mem_dump;

`ifdef DUMP_CHECKSUM_EN
  localparam int ck_extra = 1;
`else
  localparam int ck_extra = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] word_count = '0;
  logic        busy, done;

  data_mem_dump_if bus ();

  data_mem_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:2047];
  logic [7:0]  got_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          rd_ok = 1'b1;
  bit          rnd_mode = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_dat = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];

  always @(posedge clk) begin
    #1;
    if (rnd_mode) bus.tx_ready = ($urandom_range(0, 9) < 3);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", bus.tx_valid, 1'b1);
        chk("stall_data", bus.tx_data, stall_dat);
      end
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (busy && !bus.mem_rd) rd_ok = 1'b0;
      stall_prev = bus.tx_valid && !bus.tx_ready;
      stall_dat  = bus.tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic run_dump(input string tag, input logic [10:0] base, input logic [11:0] cnt,
                          input int exp_cyc);
    logic [7:0] exp_q [$];
    logic [7:0] ck;
    logic [15:0] w;
    int n, cyc;
    bit seen;
    n  = (cnt > 12'd2048) ? 2048 : int'(cnt);
    ck = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = ram[11'(int'(base) + i)];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      ck = ck ^ w[15:8] ^ w[7:0];
    end
    if (ck_extra == 1) exp_q.push_back(ck);
    got_q.delete();
    rd_ok = 1'b1;
    @(posedge clk); #1;
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = ~base;
    word_count = 12'd3;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done"}, done, 1'b1);
    if (exp_cyc > 0) chk({tag, "_cycles"}, cyc, exp_cyc);
    start = 1'b1;  // lands on the FINISH cycle and must be ignored
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_width"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF,
          {24'h0, exp_q[i]});
    chk({tag, "_mem_rd_held"}, rd_ok, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 16'(i * 16'h0123) ^ 16'h5A5A;
    ram[11'h010] = 16'hA55A;
    ram[11'h011] = 16'h1234;
    ram[11'h7FF] = 16'hBEEF;
    ram[11'h000] = 16'hCAFE;
    for (int i = 0; i < 16; i++) ram[11'h100 + i] = {8'(2 * i), 8'(2 * i + 1)};
    bus.tx_ready = 1'b1;
    bus.mem_data = '0;

    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_rd", bus.mem_rd, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 11'h000);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two words, free-running UART, with a stray start mid-dump
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join_none
    run_dump("basic", 11'h010, 12'd2, 9 + ck_extra);
    chk("basic_b0", got_q[0], 8'hA5);
    chk("basic_b1", got_q[1], 8'h5A);
    chk("basic_b2", got_q[2], 8'h12);
    chk("basic_b3", got_q[3], 8'h34);
`ifdef DUMP_CHECKSUM_EN
    chk("basic_csum", got_q[4], 8'hD9);
`else
    chk("basic_len4", got_q.size(), 4);
`endif

    run_dump("wrap", 11'h7FF, 12'd2, 9 + ck_extra);
    chk("wrap_b0", got_q[0], 8'hBE);
    chk("wrap_b2", got_q[2], 8'hCA);
    chk("wrap_b3", got_q[3], 8'hFE);

    run_dump("zero", 11'h123, 12'd0, 1 + ck_extra);

    rnd_mode = 1'b1;
    run_dump("rnd16", 11'h100, 12'd16, 0);
    chk("rnd16_b31", got_q[31], 8'h1F);
    rnd_mode = 1'b0;
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;

    // Reset while the low byte of the first word is on the wire
    got_q.delete();
    @(posedge clk); #1;
    base_addr  = 11'h010;
    word_count = 12'd2;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_lo_byte", bus.tx_data, 8'h5A);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_mem_rd", bus.mem_rd, 1'b0);
    chk("abort_mem_addr", bus.mem_addr, 11'h000);
    chk("abort_tx_valid", bus.tx_valid, 1'b0);
    chk("abort_tx_data", bus.tx_data, 8'h00);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 1'b0);
    run_dump("after_rst", 11'h010, 12'd2, 9 + ck_extra);

    // Oversized count saturates to the full memory, wrapping from base
    run_dump("sat", 11'h005, 12'hFFF, 4 * 2048 + 1 + ck_extra);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
